uart_packet_ctrl: RTL and testbench

Framing controller that sits directly behind `uart_receive` and sequences its byte stream into validated command packets. It hunts for a sync byte, captures ID and length, and streams the payload into an external payload buffer through a write port. It then verifies an additive checksum and presents the command to downstream logic with a valid/ready handshake. Malformed, oversized, stalled, or overrun traffic is dropped and flagged with single-cycle error pulses.

---
 rtl/uart_pkt_pkg.sv | 25 ++
 rtl/uart_pkt_timer.sv | 43 ++++
 rtl/uart_packet_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_uart_packet_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared constants, state encoding and checksum helper for the UART packet framing controller.
package uart_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         CHAR_BITS = 10;

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_ID      = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_HOLD    = 3'd5
    } pkt_state_t;

    function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

    // States in which a stalled sender is timed out.
    function automatic logic timed_state(input pkt_state_t s);
        return (s == ST_ID) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/uart_pkt_timer.sv
// Inter-byte timer: counts while enabled, clears on request, flags the last cycle before wrap.
module uart_pkt_timer #(
    parameter int  LIMIT = 416_640,
    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    input  logic count_en_in,
    output logic expire_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_in) begin
            count_d = '0;
        end else if (count_en_in) begin
            if (count_q == LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1'b1);
            end
        end else begin
            count_d = count_q;
        end
    end

    assign expire_out = count_en_in && (count_q == LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_packet_ctrl.sv
// Packet framing controller behind uart_receive: sync hunt, header capture, payload streaming, checksum.
// Define UART_PKT_TIMEOUT_EN to build the inter-byte timeout; otherwise err_timeout_out is held low.
module uart_packet_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int  INPUT_CLOCK_FREQ = 100_000_000,
    parameter int  BAUD_RATE        = 9600,
    parameter int  MAX_PAYLOAD      = 16,
    parameter int  TIMEOUT_BYTES    = 4,
    localparam int ADDR_W           = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1,
    localparam int LEN_W            = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rx_valid_in,
    input  logic [7:0]        rx_byte_in,
    output logic              pay_we_out,
    output logic [ADDR_W-1:0] pay_addr_out,
    output logic [7:0]        pay_data_out,
    output logic              cmd_valid_out,
    input  logic              cmd_ready_in,
    output logic [7:0]        cmd_id_out,
    output logic [LEN_W-1:0]  cmd_len_out,
    output logic              busy_out,
    output logic              err_chk_out,
    output logic              err_len_out,
    output logic              err_timeout_out,
    output logic              overrun_out
);

    localparam int         TIMEOUT_CYCLES = TIMEOUT_BYTES * CHAR_BITS * (INPUT_CLOCK_FREQ / BAUD_RATE);
    localparam logic [7:0] MAX_LEN        = 8'(MAX_PAYLOAD);

    if ((MAX_PAYLOAD < 1) || (MAX_PAYLOAD > 255) || (TIMEOUT_CYCLES < 2)) begin : g_bad_cfg
        $error("uart_packet_ctrl: unsupported parameter set");
    end

    pkt_state_t        state_q, state_d;
    logic [7:0]        acc_q, acc_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        id_q, id_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              busy_q, busy_d;
    logic              err_chk_q, err_chk_d;
    logic              err_len_q, err_len_d;
    logic              overrun_q, overrun_d;
    logic              timer_expire_s;

`ifdef UART_PKT_TIMEOUT_EN
    logic timer_run_s;
    logic tmo_q;
    logic tmo_d;

    assign timer_run_s = timed_state(state_q);

    uart_pkt_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clear_in    (rx_valid_in || !timer_run_s),
        .count_en_in (timer_run_s),
        .expire_out  (timer_expire_s)
    );

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign tmo_d           = timer_expire_s && !rx_valid_in;
    assign err_timeout_out = tmo_q;
`else
    assign timer_expire_s  = 1'b0;
    assign err_timeout_out = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        id_d      = id_q;
        len_d     = len_q;
        valid_d   = valid_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        overrun_d = 1'b0;

        if (state_q == ST_HOLD) begin
            overrun_d = rx_valid_in;
            if (valid_q && cmd_ready_in) begin
                valid_d = 1'b0;
                state_d = ST_SYNC;
            end else begin
                valid_d = valid_q;
                state_d = ST_HOLD;
            end
        end else if (rx_valid_in) begin
            case (state_q)
                ST_SYNC: begin
                    if (rx_byte_in == SYNC_BYTE) begin
                        state_d = ST_ID;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_ID: begin
                    id_d    = rx_byte_in;
                    acc_d   = rx_byte_in;
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    if (rx_byte_in > MAX_LEN) begin
                        err_len_d = 1'b1;
                        state_d   = ST_SYNC;
                    end else begin
                        len_d = LEN_W'(rx_byte_in);
                        acc_d = chk_add(acc_q, rx_byte_in);
                        idx_d = '0;
                        if (rx_byte_in == 8'd0) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    we_d   = 1'b1;
                    addr_d = idx_q;
                    data_d = rx_byte_in;
                    acc_d  = chk_add(acc_q, rx_byte_in);
                    idx_d  = idx_q + ADDR_W'(1'b1);
                    if ((LEN_W'(idx_q) + LEN_W'(1'b1)) == len_q) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_CHECK: begin
                    if (rx_byte_in == acc_q) begin
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = ST_SYNC;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end else if (timer_expire_s) begin
            state_d = ST_SYNC;
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != ST_SYNC);
    end

    // Frame state and every output register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_SYNC;
            acc_q     <= 8'd0;
            idx_q     <= '0;
            id_q      <= 8'd0;
            len_q     <= '0;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= 8'd0;
            busy_q    <= 1'b0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_PKT_TIMEOUT_EN
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            id_q      <= id_d;
            len_q     <= len_d;
            valid_q   <= valid_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            overrun_q <= overrun_d;
`ifdef UART_PKT_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign pay_we_out    = we_q;
    assign pay_addr_out  = addr_q;
    assign pay_data_out  = data_q;
    assign cmd_valid_out = valid_q;
    assign cmd_id_out    = id_q;
    assign cmd_len_out   = len_q;
    assign busy_out      = busy_q;
    assign err_chk_out   = err_chk_q;
    assign err_len_out   = err_len_q;
    assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_uart_packet_ctrl.sv
// Self-checking bench for uart_packet_ctrl: frame vector table plus hand-written timeout, back-pressure and reset sequences.
module tb_uart_packet_ctrl;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 9600;
    localparam int TO_CYC = 4 * 10 * (CLK_HZ / BAUD);  // 4160 cycles with the reduced clock

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rx_valid_in;
    logic [7:0] rx_byte_in;
    logic       cmd_ready_in;
    logic       pay_we_out;
    logic [3:0] pay_addr_out;
    logic [7:0] pay_data_out;
    logic       cmd_valid_out;
    logic [7:0] cmd_id_out;
    logic [4:0] cmd_len_out;
    logic       busy_out;
    logic       err_chk_out;
    logic       err_len_out;
    logic       err_timeout_out;
    logic       overrun_out;

    uart_packet_ctrl #(
        .INPUT_CLOCK_FREQ(CLK_HZ),
        .BAUD_RATE       (BAUD),
        .MAX_PAYLOAD     (16),
        .TIMEOUT_BYTES   (4)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rx_valid_in    (rx_valid_in),
        .rx_byte_in     (rx_byte_in),
        .pay_we_out     (pay_we_out),
        .pay_addr_out   (pay_addr_out),
        .pay_data_out   (pay_data_out),
        .cmd_valid_out  (cmd_valid_out),
        .cmd_ready_in   (cmd_ready_in),
        .cmd_id_out     (cmd_id_out),
        .cmd_len_out    (cmd_len_out),
        .busy_out       (busy_out),
        .err_chk_out    (err_chk_out),
        .err_len_out    (err_len_out),
        .err_timeout_out(err_timeout_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {logic [3:0] addr; logic [7:0] data;} wr_t;
    typedef struct packed {logic [7:0] id; logic [4:0] len;} cmd_t;
    typedef struct {
        int         n;
        int         pay_off;
        int         n_pay;
        bit         valid;
        logic [7:0] id;
        logic [4:0] len;
        int         chk_err;
        int         len_err;
    } vec_t;

    wr_t        exp_wr_q[$];
    cmd_t       exp_cmd_q[$];
    logic [7:0] pool[$];
    vec_t       vecs[$];

    int n_cmp = 0;
    int n_err = 0;
    int cnt_wr = 0, cnt_val = 0, cnt_chk = 0, cnt_len = 0, cnt_tmo = 0, cnt_ovr = 0;
    int vlen = 0, last_vlen = 0;
    logic prev_v = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: payload writes and command presentations are popped as the DUT produces them.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (pay_we_out) begin
                cnt_wr++;
                if (exp_wr_q.size() == 0) begin
                    check("write_queue_size", 64'(exp_wr_q.size()), 64'd1);
                end else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    check("pay_addr", 64'(pay_addr_out), 64'(e.addr));
                    check("pay_data", 64'(pay_data_out), 64'(e.data));
                end
            end
            if (cmd_valid_out && !prev_v) begin
                cnt_val++;
                vlen = 1;
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_queue_size", 64'(exp_cmd_q.size()), 64'd1);
                end else begin
                    cmd_t c;
                    c = exp_cmd_q.pop_front();
                    check("cmd_id", 64'(cmd_id_out), 64'(c.id));
                    check("cmd_len", 64'(cmd_len_out), 64'(c.len));
                end
            end else if (cmd_valid_out) begin
                vlen++;
            end else if (prev_v) begin
                last_vlen = vlen;
            end else begin
                vlen = 0;
            end
            cnt_chk += int'(err_chk_out);
            cnt_len += int'(err_len_out);
            cnt_tmo += int'(err_timeout_out);
            cnt_ovr += int'(overrun_out);
        end
        prev_v = cmd_valid_out;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_in);
        #1;
        rx_valid_in = 1'b1;
        rx_byte_in  = b;
        @(posedge clk_in);
        #1;
        rx_valid_in = 1'b0;
    endtask

    task automatic add_vec(input int n, input int pay_off, input int n_pay, input bit valid,
                           input logic [7:0] id, input logic [4:0] len, input int chk_err, input int len_err);
        vec_t v;
        v.n = n; v.pay_off = pay_off; v.n_pay = n_pay; v.valid = valid;
        v.id = id; v.len = len; v.chk_err = chk_err; v.len_err = len_err;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input int vi, input int start);
        vec_t v;
        int b_wr, b_val, b_chk, b_len, b_tmo, b_ovr;
        v = vecs[vi];
        b_wr = cnt_wr; b_val = cnt_val; b_chk = cnt_chk; b_len = cnt_len; b_tmo = cnt_tmo; b_ovr = cnt_ovr;
        for (int j = 0; j < v.n; j++) begin
            if ((j >= v.pay_off) && (j < v.pay_off + v.n_pay)) begin
                exp_wr_q.push_back(wr_t'{addr: 4'(j - v.pay_off), data: pool[start + j]});
            end
            if ((j == v.n - 1) && v.valid) begin
                exp_cmd_q.push_back(cmd_t'{id: v.id, len: v.len});
            end
            send_byte(pool[start + j]);
            idle(2);
        end
        idle(3);
        @(negedge clk_in);
        check($sformatf("v%0d_writes", vi), 64'(cnt_wr - b_wr), 64'(v.n_pay));
        check($sformatf("v%0d_valid_count", vi), 64'(cnt_val - b_val), 64'(v.valid));
        check($sformatf("v%0d_err_chk", vi), 64'(cnt_chk - b_chk), 64'(v.chk_err));
        check($sformatf("v%0d_err_len", vi), 64'(cnt_len - b_len), 64'(v.len_err));
        check($sformatf("v%0d_err_tmo", vi), 64'(cnt_tmo - b_tmo), 64'd0);
        check($sformatf("v%0d_overrun", vi), 64'(cnt_ovr - b_ovr), 64'd0);
        check($sformatf("v%0d_busy", vi), 64'(busy_out), 64'd0);
        check($sformatf("v%0d_pending", vi), 64'(exp_wr_q.size() + exp_cmd_q.size()), 64'd0);
        if (v.valid) begin
            check($sformatf("v%0d_valid_width", vi), 64'(last_vlen), 64'd1);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({pay_we_out, pay_addr_out, pay_data_out, cmd_valid_out, cmd_id_out, cmd_len_out,
                    busy_out, err_chk_out, err_len_out, err_timeout_out, overrun_out});
    endfunction

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int start;
        int b_tmo, b_ovr, b_val, b_wr, waited;
        bit seen;

        rst_in = 1'b1; rx_valid_in = 1'b0; rx_byte_in = 8'd0; cmd_ready_in = 1'b1;

        pool = {pool, 8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h45};
        add_vec(6, 3, 2, 1'b1, 8'h10, 5'd2, 0, 0);
        pool = {pool, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h07, 8'h00, 8'h07};
        add_vec(7, 0, 0, 1'b1, 8'h07, 5'd0, 0, 0);
        pool = {pool, 8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h46};
        add_vec(6, 3, 2, 1'b0, 8'h00, 5'd0, 1, 0);
        pool = {pool, 8'hA5, 8'h01, 8'h11};
        add_vec(3, 0, 0, 1'b0, 8'h00, 5'd0, 0, 1);
        pool = {pool, 8'hA5, 8'h01, 8'h00, 8'h01};
        add_vec(4, 0, 0, 1'b1, 8'h01, 5'd0, 0, 0);
        pool = {pool, 8'hA5, 8'h20, 8'h10};
        for (int i = 1; i <= 16; i++) pool.push_back(8'(i));
        pool = {pool, 8'hB8};
        add_vec(20, 3, 16, 1'b1, 8'h20, 5'd16, 0, 0);
        pool = {pool, 8'hA5, 8'hFF, 8'h01, 8'hFF, 8'hFF};
        add_vec(5, 3, 1, 1'b1, 8'hFF, 5'd1, 0, 0);
        pool = {pool, 8'hA5, 8'hA5, 8'h00, 8'hA5};
        add_vec(4, 0, 0, 1'b1, 8'hA5, 5'd0, 0, 0);

        idle(3);
        @(negedge clk_in);
        check("reset_outputs", all_outputs(), 64'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        start = 0;
        for (int vi = 0; vi < vecs.size(); vi++) begin
            run_vec(vi, start);
            start += vecs[vi].n;
        end

`ifdef UART_PKT_TIMEOUT_EN
        // Silence after the ID byte: the pulse lands exactly TO_CYC edges after that byte is sampled.
        b_tmo = cnt_tmo;
        send_byte(8'hA5);
        send_byte(8'h10);
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < TO_CYC + 50) begin
            @(posedge clk_in);
            #1;
            waited++;
            seen = err_timeout_out;
        end
        check("timeout_latency", 64'(waited), 64'(TO_CYC));
        idle(3);
        @(negedge clk_in);
        check("timeout_pulse_count", 64'(cnt_tmo - b_tmo), 64'd1);
        check("timeout_busy", 64'(busy_out), 64'd0);

        // A byte sampled on the expiry edge wins and the frame continues.
        b_tmo = cnt_tmo;
        send_byte(8'hA5);
        send_byte(8'h10);
        repeat (TO_CYC - 2) @(posedge clk_in);
        send_byte(8'h00);
        idle(4);
        @(negedge clk_in);
        check("expiry_collision_no_tmo", 64'(cnt_tmo - b_tmo), 64'd0);
        check("expiry_collision_busy", 64'(busy_out), 64'd1);
        exp_cmd_q.push_back(cmd_t'{id: 8'h10, len: 5'd0});
        send_byte(8'h10);
        idle(3);
        @(negedge clk_in);
        check("expiry_collision_done", 64'(exp_cmd_q.size()), 64'd0);
`else
        b_tmo = cnt_tmo;
        send_byte(8'hA5);
        send_byte(8'h10);
        idle(TO_CYC + 20);
        @(negedge clk_in);
        check("stall_no_tmo", 64'(cnt_tmo - b_tmo), 64'd0);
        check("stall_busy", 64'(busy_out), 64'd1);
        send_byte(8'h00);
        exp_cmd_q.push_back(cmd_t'{id: 8'h10, len: 5'd0});
        send_byte(8'h10);
        idle(3);
        @(negedge clk_in);
        check("stall_done", 64'(exp_cmd_q.size()), 64'd0);
`endif

        // Back-pressure: bytes during HOLD are overruns; the held command stays put.
        cmd_ready_in = 1'b0;
        b_val = cnt_val;
        exp_wr_q.push_back(wr_t'{addr: 4'd0, data: 8'h11});
        exp_wr_q.push_back(wr_t'{addr: 4'd1, data: 8'h22});
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        exp_cmd_q.push_back(cmd_t'{id: 8'h10, len: 5'd2});
        send_byte(8'h45);
        idle(3);
        b_ovr = cnt_ovr;
        b_wr = cnt_wr;
        send_byte(8'hA5); idle(1); send_byte(8'h33); idle(1); send_byte(8'h44);
        idle(2);
        @(negedge clk_in);
        check("overrun_count", 64'(cnt_ovr - b_ovr), 64'd3);
        check("hold_valid", 64'(cmd_valid_out), 64'd1);
        check("hold_id", 64'(cmd_id_out), 64'h10);
        check("hold_len", 64'(cmd_len_out), 64'd2);
        check("hold_no_writes", 64'(cnt_wr - b_wr), 64'd0);
        check("hold_single_valid", 64'(cnt_val - b_val), 64'd1);
        @(posedge clk_in);
        #1;
        cmd_ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        cmd_ready_in = 1'b0;
        rx_valid_in  = 1'b1;
        rx_byte_in   = 8'hA5;
        @(negedge clk_in);
        check("handshake_valid_drop", 64'(cmd_valid_out), 64'd0);
        check("handshake_sync", 64'(busy_out), 64'd0);
        @(posedge clk_in);
        #1;
        rx_valid_in  = 1'b0;
        cmd_ready_in = 1'b1;
        send_byte(8'h01);
        send_byte(8'h00);
        exp_cmd_q.push_back(cmd_t'{id: 8'h01, len: 5'd0});
        send_byte(8'h01);
        idle(3);
        @(negedge clk_in);
        check("resync_after_handshake", 64'(exp_cmd_q.size()), 64'd0);

        // Reset in the middle of a payload clears every output.
        exp_wr_q.push_back(wr_t'{addr: 4'd0, data: 8'h11});
        exp_wr_q.push_back(wr_t'{addr: 4'd1, data: 8'h22});
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
        @(negedge clk_in);
        check("midframe_busy", 64'(busy_out), 64'd1);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        idle(2);
        @(negedge clk_in);
        check("midframe_reset_outputs", all_outputs(), 64'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        exp_wr_q.push_back(wr_t'{addr: 4'd0, data: 8'h11});
        exp_wr_q.push_back(wr_t'{addr: 4'd1, data: 8'h22});
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        exp_cmd_q.push_back(cmd_t'{id: 8'h10, len: 5'd2});
        send_byte(8'h45);
        idle(3);
        @(negedge clk_in);
        check("after_reset_frame", 64'(exp_wr_q.size() + exp_cmd_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
